// File: rtl/stb_pkg.sv
// Store buffer shared types and defaults.
// Entry layout is common to the FIFO and the forwarding lookup.
package stb_pkg;

  localparam int STB_DEPTH = 8;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] sel_byte;
  } stb_entry_t;

endpackage

// File: rtl/stb_fwd_lookup.sv
// Store-to-load forwarding search over the store buffer.
// Youngest valid word match wins; no byte merging.
module stb_fwd_lookup
  import stb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  stb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     wr_ptr,
  input  logic [XLEN-1:0]   ld_addr,
  output logic              hit,
  output logic [XLEN-1:0]   data,
  output logic [XLEN/8-1:0] sel_byte
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk backwards from the newest slot so the first match is the youngest.
  always_comb begin
    hit      = 1'b0;
    data     = '0;
    sel_byte = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = wr_ptr - PW'(k);
      if (!found && valid[idx] &&
          entries[idx].addr[XLEN-1:2] == ld_addr[XLEN-1:2]) begin
        found    = 1'b1;
        hit      = 1'b1;
        data     = entries[idx].wdata;
        sel_byte = entries[idx].sel_byte;
      end
    end
  end

endmodule

// File: rtl/stb_datapath.sv
// Store buffer: circular FIFO of pending stores with
// head drain port to the dcache and load forwarding.
module stb_datapath #(
  parameter int STB_DEPTH = stb_pkg::STB_DEPTH,
  parameter int XLEN      = stb_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu2stb_req,
  input  logic [XLEN-1:0]   lsu2stb_addr,
  input  logic [XLEN-1:0]   lsu2stb_wdata,
  input  logic [XLEN/8-1:0] lsu2stb_sel_byte,
  output logic              stb2lsu_ack,
  input  logic              stb_rd_en,
  input  logic              rd_sel,
  output logic [XLEN-1:0]   stb2dcache_addr,
  output logic [XLEN-1:0]   stb2dcache_wdata,
  output logic [XLEN/8-1:0] stb2dcache_sel_byte,
  output logic              stb_full,
  output logic              stb_empty,
  input  logic [XLEN-1:0]   ld_addr,
  output logic              ld_fwd_hit,
  output logic [XLEN-1:0]   ld_fwd_data,
  output logic [XLEN/8-1:0] ld_fwd_sel_byte
);

  import stb_pkg::*;

  localparam int PW = $clog2(STB_DEPTH);

  stb_entry_t           mem [STB_DEPTH];
  stb_entry_t           wr_entry;
  logic [STB_DEPTH-1:0] valid;
  logic [STB_DEPTH-1:0] fwd_valid;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic                 pop;

  assign stb_empty   = (count == '0);
  assign stb_full    = (count == (PW+1)'(STB_DEPTH));
  assign stb2lsu_ack = lsu2stb_req && !stb_full;
  assign pop         = stb_rd_en && !stb_empty;

  assign wr_entry.addr     = lsu2stb_addr;
  assign wr_entry.wdata    = lsu2stb_wdata;
  assign wr_entry.sel_byte = lsu2stb_sel_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (stb2lsu_ack) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      unique case ({stb2lsu_ack, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (stb2lsu_ack) mem[wr_ptr] <= wr_entry;
  end

  assign stb2dcache_addr     = rd_sel ? mem[rd_ptr].addr     : '0;
  assign stb2dcache_wdata    = rd_sel ? mem[rd_ptr].wdata    : '0;
  assign stb2dcache_sel_byte = rd_sel ? mem[rd_ptr].sel_byte : '0;

  // A slot being filled this cycle is not yet visible to loads.
  always_comb begin
    fwd_valid = valid;
    if (stb2lsu_ack) fwd_valid[wr_ptr] = 1'b0;
  end

  stb_fwd_lookup #(
    .DEPTH (STB_DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries  (mem),
    .valid    (fwd_valid),
    .wr_ptr   (wr_ptr),
    .ld_addr  (ld_addr),
    .hit      (ld_fwd_hit),
    .data     (ld_fwd_data),
    .sel_byte (ld_fwd_sel_byte)
  );

endmodule
